id_ex_stage: RTL and testbench

- Pipeline register between decode and execute that directly feeds alu_if (aluop, ra, rb).
- Latches decoded operands and control on each enabled cycle, then resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects register or immediate for the B operand.
- Detects load-use hazards against the decode-stage instruction and supports stall (hold) and flush (bubble).

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/forward_unit.sv | 34 +++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: words, register indices, ALU opcodes and the
// forwarding-source select used by the ID/EX operand bypass.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Where an operand comes from: the registered read data or a later stage.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_t;

  // A write-back source hits only for a nonzero index it actually writes.
  function automatic logic wb_hit(input logic regwen, input regbits_t wsel,
                                  input regbits_t src);
    return regwen && (wsel == src) && (src != '0);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one source register. Reports which later stage
// (if any) owns the newest value and presents that stage's result; the
// caller keeps its own registered read data for the FWD_REG case.
module forward_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src,
  input  logic              exm_regwen,
  input  logic [REG_W-1:0]  exm_wsel,
  input  logic [WORD_W-1:0] exm_dat,
  input  logic              mwb_regwen,
  input  logic [REG_W-1:0]  mwb_wsel,
  input  logic [WORD_W-1:0] mwb_dat,
  output fwd_t              sel,
  output logic [WORD_W-1:0] dat
);

  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    sel = FWD_REG;
    dat = '0;
    if (wb_hit(exm_regwen, exm_wsel, src)) begin
      sel = FWD_EXM;
      dat = exm_dat;
    end else if (wb_hit(mwb_regwen, mwb_wsel, src)) begin
      sel = FWD_MWB;
      dat = mwb_dat;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded operands and
// control, bypasses results from EX/MEM and MEM/WB, picks register or
// immediate for operand B and flags load-use hazards against decode.
module id_ex_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              d_valid,
  input  aluop_t            d_aluop,
  input  logic [WORD_W-1:0] d_rdat1,
  input  logic [WORD_W-1:0] d_rdat2,
  input  logic [WORD_W-1:0] d_imm,
  input  logic              d_alusrc,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [REG_W-1:0]  d_wsel,
  input  logic              d_regwen,
  input  logic              d_memread,
  input  logic              exm_regwen,
  input  logic [REG_W-1:0]  exm_wsel,
  input  logic [WORD_W-1:0] exm_dat,
  input  logic              mwb_regwen,
  input  logic [REG_W-1:0]  mwb_wsel,
  input  logic [WORD_W-1:0] mwb_dat,
  output aluop_t            aluop,
  output logic [WORD_W-1:0] ra,
  output logic [WORD_W-1:0] rb,
  output logic              e_valid,
  output logic              e_regwen,
  output logic              e_memread,
  output logic [REG_W-1:0]  e_wsel,
  output logic [WORD_W-1:0] e_store_dat,
  output logic              load_use
);

  logic              r_valid;
  logic              r_regwen;
  logic              r_memread;
  aluop_t            r_aluop;
  logic [WORD_W-1:0] r_rdat1;
  logic [WORD_W-1:0] r_rdat2;
  logic [WORD_W-1:0] r_imm;
  logic              r_alusrc;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_wsel;

  fwd_t              fwd_a_sel;
  fwd_t              fwd_b_sel;
  logic [WORD_W-1:0] fwd_a_dat;
  logic [WORD_W-1:0] fwd_b_dat;
  logic [WORD_W-1:0] rt_val;

  // Stage register: reset beats flush beats stall beats capture. A flush
  // clears data fields too so a bubble carries no stale operands.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_valid   <= 1'b0;
      r_regwen  <= 1'b0;
      r_memread <= 1'b0;
      r_aluop   <= ALU_SLL;
      r_rdat1   <= '0;
      r_rdat2   <= '0;
      r_imm     <= '0;
      r_alusrc  <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_wsel    <= '0;
    end else if (!stall) begin
      r_valid   <= d_valid;
      r_regwen  <= d_regwen;
      r_memread <= d_memread;
      r_aluop   <= d_aluop;
      r_rdat1   <= d_rdat1;
      r_rdat2   <= d_rdat2;
      r_imm     <= d_imm;
      r_alusrc  <= d_alusrc;
      r_rs      <= d_rs;
      r_rt      <= d_rt;
      r_wsel    <= d_wsel;
    end
  end

  forward_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_a (
    .src        (r_rs),
    .exm_regwen (exm_regwen),
    .exm_wsel   (exm_wsel),
    .exm_dat    (exm_dat),
    .mwb_regwen (mwb_regwen),
    .mwb_wsel   (mwb_wsel),
    .mwb_dat    (mwb_dat),
    .sel        (fwd_a_sel),
    .dat        (fwd_a_dat)
  );

  forward_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_b (
    .src        (r_rt),
    .exm_regwen (exm_regwen),
    .exm_wsel   (exm_wsel),
    .exm_dat    (exm_dat),
    .mwb_regwen (mwb_regwen),
    .mwb_wsel   (mwb_wsel),
    .mwb_dat    (mwb_dat),
    .sel        (fwd_b_sel),
    .dat        (fwd_b_dat)
  );

  // Operand muxing; outputs stay live during bubbles, consumers gate on e_valid.
  always_comb begin
    ra     = (fwd_a_sel == FWD_REG) ? r_rdat1 : fwd_a_dat;
    rt_val = (fwd_b_sel == FWD_REG) ? r_rdat2 : fwd_b_dat;
    rb     = r_alusrc ? r_imm : rt_val;
  end

  assign e_store_dat = rt_val;
  assign aluop       = r_aluop;
  assign e_valid     = r_valid;
  assign e_regwen    = r_regwen;
  assign e_memread   = r_memread;
  assign e_wsel      = r_wsel;

  // Load in EX feeding a register decode reads; rt is checked even for
  // immediate forms since a store still consumes it.
  always_comb begin
    load_use = r_valid && r_memread && r_regwen && (r_wsel != '0) && d_valid &&
               ((r_wsel == d_rs) || (r_wsel == d_rt));
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps then randomized cycles, all checked
// against a behavioural model of the stage contents.
module tb_id_ex_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, stall, flush;
  logic        d_valid, d_alusrc, d_regwen, d_memread;
  aluop_t      d_aluop;
  logic [31:0] d_rdat1, d_rdat2, d_imm;
  logic [4:0]  d_rs, d_rt, d_wsel;
  logic        exm_regwen, mwb_regwen;
  logic [4:0]  exm_wsel, mwb_wsel;
  logic [31:0] exm_dat, mwb_dat;
  aluop_t      aluop;
  logic [31:0] ra, rb, e_store_dat;
  logic        e_valid, e_regwen, e_memread, load_use;
  logic [4:0]  e_wsel;

  int checks = 0;
  int failures = 0;

  // model of what the stage should be holding
  logic        m_valid, m_regwen, m_memread, m_alusrc;
  aluop_t      m_aluop;
  logic [31:0] m_rdat1, m_rdat2, m_imm;
  logic [4:0]  m_rs, m_rt, m_wsel;

  always #5 CLK = ~CLK;

  id_ex_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .d_valid(d_valid), .d_aluop(d_aluop), .d_rdat1(d_rdat1), .d_rdat2(d_rdat2),
    .d_imm(d_imm), .d_alusrc(d_alusrc), .d_rs(d_rs), .d_rt(d_rt), .d_wsel(d_wsel),
    .d_regwen(d_regwen), .d_memread(d_memread),
    .exm_regwen(exm_regwen), .exm_wsel(exm_wsel), .exm_dat(exm_dat),
    .mwb_regwen(mwb_regwen), .mwb_wsel(mwb_wsel), .mwb_dat(mwb_dat),
    .aluop(aluop), .ra(ra), .rb(rb), .e_valid(e_valid), .e_regwen(e_regwen),
    .e_memread(e_memread), .e_wsel(e_wsel), .e_store_dat(e_store_dat),
    .load_use(load_use)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // newest producer of a register value, EX/MEM before MEM/WB, $0 never bypassed
  function automatic logic [31:0] newest(input logic [4:0] src, input logic [31:0] regv);
    if (src == 5'd0) return regv;
    if (exm_regwen && exm_wsel == src) return exm_dat;
    if (mwb_regwen && mwb_wsel == src) return mwb_dat;
    return regv;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] exp_rt;
    logic        exp_lu;
    exp_rt = newest(m_rt, m_rdat2);
    exp_lu = m_valid && m_memread && m_regwen && m_wsel != 0 && d_valid &&
             (m_wsel == d_rs || m_wsel == d_rt);
    chk({tag, ".e_valid"},   {31'd0, e_valid},   {31'd0, m_valid});
    chk({tag, ".e_regwen"},  {31'd0, e_regwen},  {31'd0, m_regwen});
    chk({tag, ".e_memread"}, {31'd0, e_memread}, {31'd0, m_memread});
    chk({tag, ".e_wsel"},    {27'd0, e_wsel},    {27'd0, m_wsel});
    chk({tag, ".aluop"},     {28'd0, aluop},     {28'd0, m_aluop});
    chk({tag, ".ra"},        ra,                 newest(m_rs, m_rdat1));
    chk({tag, ".rb"},        rb,                 m_alusrc ? m_imm : exp_rt);
    chk({tag, ".store"},     e_store_dat,        exp_rt);
    chk({tag, ".load_use"},  {31'd0, load_use},  {31'd0, exp_lu});
  endtask

  task automatic model_clear();
    m_valid = 0; m_regwen = 0; m_memread = 0; m_alusrc = 0; m_aluop = ALU_SLL;
    m_rdat1 = 0; m_rdat2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wsel = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST || flush) model_clear();
    else if (!stall) begin
      m_valid = d_valid; m_regwen = d_regwen; m_memread = d_memread;
      m_alusrc = d_alusrc; m_aluop = d_aluop; m_rdat1 = d_rdat1;
      m_rdat2 = d_rdat2; m_imm = d_imm; m_rs = d_rs; m_rt = d_rt; m_wsel = d_wsel;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; d_valid = 0; d_aluop = ALU_SLL; d_rdat1 = 0; d_rdat2 = 0;
    d_imm = 0; d_alusrc = 0; d_rs = 0; d_rt = 0; d_wsel = 0; d_regwen = 0;
    d_memread = 0; exm_regwen = 0; exm_wsel = 0; exm_dat = 0;
    mwb_regwen = 0; mwb_wsel = 0; mwb_dat = 0;
  endtask

  initial begin
    model_clear();
    idle_inputs();

    // reset then idle
    RST = 1;
    tick(); check_all("rst1");
    tick(); check_all("rst2");
    chk("rst_ra", ra, 32'h0);
    chk("rst_valid", {31'd0, e_valid}, 32'h0);
    RST = 0;
    tick(); check_all("post_rst");
    chk("post_rst_lu", {31'd0, load_use}, 32'h0);

    // plain register op
    d_valid = 1; d_aluop = ALU_ADD; d_rdat1 = 32'h5; d_rdat2 = 32'h7;
    d_rs = 5'd1; d_rt = 5'd2; d_wsel = 5'd4; d_regwen = 1;
    tick();
    chk("plain_aluop", {28'd0, aluop}, {28'd0, ALU_ADD});
    chk("plain_ra", ra, 32'h5);
    chk("plain_rb", rb, 32'h7);
    chk("plain_valid", {31'd0, e_valid}, 32'h1);
    check_all("plain");

    // forwarding priority
    d_rs = 5'd8; d_rdat1 = 32'h11;
    tick();
    exm_regwen = 1; exm_wsel = 5'd8; exm_dat = 32'hAAAA_0000;
    mwb_regwen = 1; mwb_wsel = 5'd8; mwb_dat = 32'h1234_5678;
    #1; chk("fwd_exm", ra, 32'hAAAA_0000); check_all("fwd_exm");
    exm_regwen = 0;
    #1; chk("fwd_mwb", ra, 32'h1234_5678); check_all("fwd_mwb");
    d_rs = 5'd0; d_rdat1 = 32'h99;
    tick();
    exm_regwen = 1; exm_wsel = 5'd0; mwb_wsel = 5'd0;
    #1; chk("fwd_r0", ra, 32'h99); check_all("fwd_r0");

    // immediate path
    d_alusrc = 1; d_imm = 32'hFFFF_FFFC; d_rt = 5'd9; d_rdat2 = 32'h1; d_rs = 5'd1;
    exm_regwen = 1; exm_wsel = 5'd9; exm_dat = 32'h55; mwb_regwen = 0;
    tick();
    chk("imm_rb", rb, 32'hFFFF_FFFC);
    chk("imm_store", e_store_dat, 32'h55);
    check_all("imm");

    // load-use
    exm_regwen = 0; mwb_regwen = 0; d_alusrc = 0;
    d_wsel = 5'd3; d_memread = 1; d_regwen = 1; d_valid = 1; d_rs = 5'd5; d_rt = 5'd6;
    tick();
    d_rs = 5'd3; d_memread = 0; d_wsel = 5'd7;
    #1; chk("lu_hit", {31'd0, load_use}, 32'h1); check_all("lu_hit");
    flush = 1;
    tick();
    flush = 0;
    chk("lu_bubble_valid", {31'd0, e_valid}, 32'h0);
    chk("lu_bubble_lu", {31'd0, load_use}, 32'h0);
    check_all("lu_bubble");
    d_wsel = 5'd0; d_memread = 1; d_regwen = 1; d_rs = 5'd0; d_rt = 5'd0;
    tick();
    #1; chk("lu_r0", {31'd0, load_use}, 32'h0); check_all("lu_r0");

    // stall holds while decode inputs churn
    d_rdat1 = 32'h21; d_rdat2 = 32'h42; d_rs = 5'd10; d_rt = 5'd11; d_alusrc = 0;
    d_aluop = ALU_OR; d_valid = 1; d_regwen = 1; d_memread = 0; d_wsel = 5'd12;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      d_rdat1 = $urandom; d_rdat2 = $urandom; d_rs = 5'($urandom); d_rt = 5'($urandom);
      d_wsel = 5'($urandom); d_aluop = aluop_t'($urandom_range(0, 9));
      d_valid = 1'($urandom); d_alusrc = 1'($urandom);
      tick();
      chk("stall_ra", ra, 32'h21);
      chk("stall_rb", rb, 32'h42);
      chk("stall_aluop", {28'd0, aluop}, {28'd0, ALU_OR});
      chk("stall_wsel", {27'd0, e_wsel}, 32'd12);
      check_all("stall");
    end
    flush = 1;
    tick();
    chk("stall_flush_valid", {31'd0, e_valid}, 32'h0);
    check_all("stall_flush");
    stall = 0; flush = 0; d_valid = 1; d_regwen = 1; d_rdat1 = 32'h77;
    d_aluop = ALU_SUB; d_wsel = 5'd6;
    tick();
    stall = 1; RST = 1;
    tick();
    chk("rst_stall_valid", {31'd0, e_valid}, 32'h0);
    chk("rst_stall_ra", ra, 32'h0);
    chk("rst_stall_wsel", {27'd0, e_wsel}, 32'h0);
    chk("rst_stall_aluop", {28'd0, aluop}, {28'd0, ALU_SLL});
    check_all("rst_stall");
    RST = 0; stall = 0;

    // randomized traffic on a small register window so hits are common
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      d_valid = 1'($urandom); d_aluop = aluop_t'($urandom_range(0, 9));
      d_rdat1 = $urandom; d_rdat2 = $urandom; d_imm = $urandom;
      d_alusrc = 1'($urandom); d_regwen = 1'($urandom); d_memread = 1'($urandom);
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      d_wsel = 5'($urandom_range(0, 3));
      tick();
      exm_regwen = 1'($urandom); exm_wsel = 5'($urandom_range(0, 3)); exm_dat = $urandom;
      mwb_regwen = 1'($urandom); mwb_wsel = 5'($urandom_range(0, 3)); mwb_dat = $urandom;
      d_valid = 1'($urandom);
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      #1; check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
